// File: rtl/addr_gen_burst_pkg.sv
// Shared types and the sign-extension helper for the burst address generator.
package agu_pkg;
  localparam int SEXT_MAX_W = 64;

  typedef enum logic [1:0] {A2_ZERO, A2_OFF1, A2_OFF2, A2_OFF3} addr2_sel_e;
  typedef enum logic {S_IDLE, S_BURST} agu_state_e;

  // Field sits in the low in_w bits of v; callers truncate the result to their width.
  function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] v,
                                                 input int unsigned in_w);
    logic signed [SEXT_MAX_W-1:0] t;
    t = $signed(v << (SEXT_MAX_W - in_w));
    return $unsigned(t >>> (SEXT_MAX_W - in_w));
  endfunction
endpackage

// File: rtl/addr_gen_burst_if.sv
// Request bus and address stream between control FSM, address generator and memory side.
interface addr_gen_burst_if #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 8
);
  localparam int BL_W = $clog2(MAX_BURST + 1);

  logic              req_valid;
  logic              req_ready;
  logic [WIDTH-1:0]  IR_output;
  logic [WIDTH-1:0]  PC_reg_output;
  logic [WIDTH-1:0]  SR1_output;
  logic              ADDR1MUX;
  logic [1:0]        ADDR2MUX;
  logic [BL_W-1:0]   burst_len;
  logic [WIDTH-1:0]  stride;
  logic              flush;
  logic              addr_valid;
  logic              addr_ready;
  logic [WIDTH-1:0]  addr_out;
  logic              addr_last;
  logic [WIDTH-1:0]  sext_imm;
  logic              busy;

  modport slave (
    input  req_valid, IR_output, PC_reg_output, SR1_output, ADDR1MUX, ADDR2MUX,
           burst_len, stride, flush, addr_ready,
    output req_ready, addr_valid, addr_out, addr_last, sext_imm, busy
  );

  modport master (
    output req_valid, IR_output, PC_reg_output, SR1_output, ADDR1MUX, ADDR2MUX,
           burst_len, stride, flush, addr_ready,
    input  req_ready, addr_valid, addr_out, addr_last, sext_imm, busy
  );
endinterface

// File: rtl/addr_gen_burst_offset_sel.sv
// Combinational base select + sign-extended IR offset select + add.
module agu_offset_sel
  import agu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int OFF1_W = 6,
  parameter int OFF2_W = 9,
  parameter int OFF3_W = 11
) (
  input  logic [OFF3_W-1:0] i_ir,
  input  logic [WIDTH-1:0]  i_pc,
  input  logic [WIDTH-1:0]  i_sr1,
  input  logic              i_addr1_sel,
  input  addr2_sel_e        i_addr2_sel,
  output logic [WIDTH-1:0]  o_addr
);
  logic [WIDTH-1:0] w_off1, w_off2, w_off3, w_off, w_base;

  assign w_off1 = WIDTH'(sext(SEXT_MAX_W'(i_ir[OFF1_W-1:0]), OFF1_W));
  assign w_off2 = WIDTH'(sext(SEXT_MAX_W'(i_ir[OFF2_W-1:0]), OFF2_W));
  assign w_off3 = WIDTH'(sext(SEXT_MAX_W'(i_ir[OFF3_W-1:0]), OFF3_W));

  always_comb begin
    w_off = '0;
    unique case (i_addr2_sel)
      A2_OFF1: w_off = w_off1;
      A2_OFF2: w_off = w_off2;
      A2_OFF3: w_off = w_off3;
      default: w_off = '0;
    endcase
  end

  assign w_base = i_addr1_sel ? i_sr1 : i_pc;
  assign o_addr = w_base + w_off;
endmodule

// File: rtl/addr_gen_burst.sv
// Registered address generator: latches base+offset on accept, then streams a
// strided burst of addresses under valid/ready backpressure.
module addr_gen_burst
  import agu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int OFF1_W    = 6,
  parameter int OFF2_W    = 9,
  parameter int OFF3_W    = 11,
  parameter int IMM_W     = 5,
  parameter int MAX_BURST = 8
) (
  input logic               Clk,
  input logic               Reset,
  addr_gen_burst_if.slave   bus
);
  localparam int BL_W = $clog2(MAX_BURST + 1);

  agu_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_addr, r_stride, r_sext_imm, w_start;
  logic [BL_W-1:0]  r_rem, w_eff_len;
  logic             w_burst, w_accept, w_xfer, w_last, w_flush;

  agu_offset_sel #(
    .WIDTH(WIDTH), .OFF1_W(OFF1_W), .OFF2_W(OFF2_W), .OFF3_W(OFF3_W)
  ) u_offset_sel (
    .i_ir        (bus.IR_output[OFF3_W-1:0]),
    .i_pc        (bus.PC_reg_output),
    .i_sr1       (bus.SR1_output),
    .i_addr1_sel (bus.ADDR1MUX),
    .i_addr2_sel (addr2_sel_e'(bus.ADDR2MUX)),
    .o_addr      (w_start)
  );

  always_comb begin
    w_eff_len = bus.burst_len;
    if (bus.burst_len == '0)                  w_eff_len = BL_W'(1);
    else if (bus.burst_len > BL_W'(MAX_BURST)) w_eff_len = BL_W'(MAX_BURST);
  end

  assign w_burst  = (r_state == S_BURST);
  assign w_accept = !w_burst && bus.req_valid;
  assign w_xfer   = w_burst && bus.addr_ready;
  assign w_last   = w_burst && (r_rem == BL_W'(1));
  assign w_flush  = w_burst && bus.flush;

  always_comb begin
    w_state_nxt   = r_state;
    bus.req_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_state_nxt = S_BURST;
      end
      S_BURST: begin
        if (bus.flush || (bus.addr_ready && w_last)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_addr     <= '0;
      r_stride   <= '0;
      r_rem      <= '0;
      r_sext_imm <= '0;
    end else if (w_accept) begin
      r_addr     <= w_start;
      r_stride   <= bus.stride;
      r_rem      <= w_eff_len;
      r_sext_imm <= WIDTH'(sext(SEXT_MAX_W'(bus.IR_output[IMM_W-1:0]), IMM_W));
    end else begin
      if (w_xfer) begin
        r_addr <= r_addr + r_stride;
        r_rem  <= r_rem - BL_W'(1);
      end
      // A beat moving on the flush edge still counts; only the remainder is dropped.
      if (w_flush) r_rem <= '0;
    end
  end

  assign bus.addr_valid = w_burst;
  assign bus.addr_out   = r_addr;
  assign bus.addr_last  = w_last;
  assign bus.sext_imm   = r_sext_imm;
  assign bus.busy       = w_burst;
endmodule

// File: tb/tb_addr_gen_burst.sv
// Randomized bench for addr_gen_burst with a queue-based beat model and directed literal checks.
module tb_addr_gen_burst;
  import agu_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [15:0] a;
    bit          last;
  } beat_t;

  beat_t       mq[$];
  logic [15:0] tlog[$];
  logic [15:0] exp_sext = '0;
  bit          out_zero = 1'b1;
  bit          seen_rst = 1'b0;

  addr_gen_burst_if #(.WIDTH(16), .MAX_BURST(8)) bus ();

  addr_gen_burst #(
    .WIDTH(16), .OFF1_W(6), .OFF2_W(9), .OFF3_W(11), .IMM_W(5), .MAX_BURST(8)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: on accept, expand the whole burst into a queue of expected beats.
  logic [15:0] m_base;
  int          m_off, m_n;
  beat_t       m_b;
  always @(posedge Clk) begin
    if (Reset) begin
      mq.delete();
      exp_sext = '0;
      out_zero = 1'b1;
      seen_rst = 1'b1;
    end else if (mq.size() > 0) begin
      if (bus.addr_ready) begin
        tlog.push_back(bus.addr_out);
        void'(mq.pop_front());
      end
      if (bus.flush) mq.delete();
    end else if (bus.req_valid) begin
      m_base = bus.ADDR1MUX ? bus.SR1_output : bus.PC_reg_output;
      case (bus.ADDR2MUX)
        2'd1:    m_off = $signed(bus.IR_output[5:0]);
        2'd2:    m_off = $signed(bus.IR_output[8:0]);
        2'd3:    m_off = $signed(bus.IR_output[10:0]);
        default: m_off = 0;
      endcase
      m_n = (bus.burst_len == 0) ? 1 : ((bus.burst_len > 8) ? 8 : int'(bus.burst_len));
      for (int k = 0; k < m_n; k++) begin
        m_b.a    = 16'(int'(m_base) + m_off + k * int'(bus.stride));
        m_b.last = (k == m_n - 1);
        mq.push_back(m_b);
      end
      exp_sext = 16'($signed(bus.IR_output[4:0]));
      out_zero = 1'b0;
    end
  end

  always @(negedge Clk) begin
    if (seen_rst) begin
      chk("addr_valid", 32'(bus.addr_valid), 32'(mq.size() > 0));
      chk("busy", 32'(bus.busy), 32'(mq.size() > 0));
      chk("req_ready", 32'(bus.req_ready), 32'(mq.size() == 0));
      chk("sext_imm", 32'(bus.sext_imm), 32'(exp_sext));
      if (mq.size() > 0) begin
        chk("addr_out", 32'(bus.addr_out), 32'(mq[0].a));
        chk("addr_last", 32'(bus.addr_last), 32'(mq[0].last));
      end else if (out_zero) begin
        chk("addr_out_rst", 32'(bus.addr_out), 32'h0);
        chk("addr_last_rst", 32'(bus.addr_last), 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic req(input logic [15:0] pc, input logic [15:0] sr1, input logic [15:0] ir,
                     input logic a1, input logic [1:0] a2, input logic [3:0] len,
                     input logic [15:0] st);
    bus.PC_reg_output = pc;
    bus.SR1_output    = sr1;
    bus.IR_output     = ir;
    bus.ADDR1MUX      = a1;
    bus.ADDR2MUX      = a2;
    bus.burst_len     = len;
    bus.stride        = st;
    bus.req_valid     = 1'b1;
    tick();
    bus.req_valid     = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while (mq.size() != 0 && n < 300) begin
      bus.addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    if (mq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL wait_idle timeout remaining=%0d required=0", mq.size());
    end
    bus.addr_ready = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 0; bus.IR_output = 0; bus.PC_reg_output = 0; bus.SR1_output = 0;
    bus.ADDR1MUX = 0; bus.ADDR2MUX = 0; bus.burst_len = 0; bus.stride = 0;
    bus.flush = 0; bus.addr_ready = 1;
    tick(); tick();
    Reset = 1'b0;
    chk("rst_valid", 32'(bus.addr_valid), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h1);

    // 1: PC + OFF2 sext, 3 beats
    tlog.delete();
    req(16'h3000, 16'h0, 16'h01FE, 1'b0, 2'd2, 4'd3, 16'h1);
    wait_idle(0);
    chk("t1_n", tlog.size(), 3);
    chk("t1_b0", 32'(tlog[0]), 32'h2FFE);
    chk("t1_b1", 32'(tlog[1]), 32'h2FFF);
    chk("t1_b2", 32'(tlog[2]), 32'h3000);
    chk("t1_busy", 32'(bus.busy), 32'h0);

    // 2: SR1 + OFF1 wraps
    tlog.delete();
    req(16'h0, 16'hFFFF, 16'h0001, 1'b1, 2'd1, 4'd2, 16'h1);
    wait_idle(0);
    chk("t2_n", tlog.size(), 2);
    chk("t2_b0", 32'(tlog[0]), 32'h0000);
    chk("t2_b1", 32'(tlog[1]), 32'h0001);

    // 3: negative stride with a 3-cycle stall on beat 2
    tlog.delete();
    req(16'h0100, 16'h0, 16'h0, 1'b0, 2'd0, 4'd4, 16'hFFFE);
    bus.addr_ready = 1'b1;
    tick();
    bus.addr_ready = 1'b0;
    tick(); tick(); tick();
    chk("t3_hold", 32'(bus.addr_out), 32'h00FE);
    wait_idle(0);
    chk("t3_n", tlog.size(), 4);
    chk("t3_b0", 32'(tlog[0]), 32'h0100);
    chk("t3_b1", 32'(tlog[1]), 32'h00FE);
    chk("t3_b2", 32'(tlog[2]), 32'h00FC);
    chk("t3_b3", 32'(tlog[3]), 32'h00FA);

    // 4: length 0 and over-length
    tlog.delete();
    req(16'h1234, 16'h0, 16'h0, 1'b0, 2'd0, 4'd0, 16'h3);
    wait_idle(0);
    chk("t4_len0", tlog.size(), 1);
    tlog.delete();
    req(16'h1234, 16'h0, 16'h0, 1'b0, 2'd0, 4'd11, 16'h3);
    wait_idle(0);
    chk("t4_clamp", tlog.size(), 8);
    chk("t4_lastaddr", 32'(tlog[7]), 32'h1249);

    // 5: reset mid-burst, then a fresh request
    req(16'h4000, 16'h0, 16'h0, 1'b0, 2'd0, 4'd5, 16'h1);
    bus.addr_ready = 1'b1;
    tick();
    Reset = 1'b1;
    tick();
    chk("t5_valid", 32'(bus.addr_valid), 32'h0);
    chk("t5_addr", 32'(bus.addr_out), 32'h0);
    chk("t5_ready", 32'(bus.req_ready), 32'h1);
    Reset = 1'b0;
    tlog.delete();
    req(16'h5000, 16'h0, 16'h0, 1'b0, 2'd0, 4'd2, 16'h10);
    wait_idle(0);
    chk("t5_n", tlog.size(), 2);
    chk("t5_b0", 32'(tlog[0]), 32'h5000);
    chk("t5_b1", 32'(tlog[1]), 32'h5010);

    // 6: flush with concurrent transfer on beat 1; flush in IDLE ignored
    tlog.delete();
    req(16'h0200, 16'h0, 16'h0010, 1'b0, 2'd0, 4'd4, 16'h4);
    bus.addr_ready = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t6_n", tlog.size(), 1);
    chk("t6_b0", 32'(tlog[0]), 32'h0200);
    chk("t6_busy", 32'(bus.busy), 32'h0);
    chk("t6_sext", 32'(bus.sext_imm), 32'hFFF0);
    bus.flush = 1'b1;
    req(16'h0300, 16'h0, 16'h0, 1'b0, 2'd0, 4'd1, 16'h1);
    bus.flush = 1'b0;
    chk("t6_idle_flush", 32'(bus.addr_valid), 32'h1);
    wait_idle(0);

    // Random traffic with backpressure, occasional flush and reset
    for (int i = 0; i < 60; i++) begin
      int n;
      req(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom),
          4'($urandom), 16'($urandom));
      n = 0;
      while (mq.size() != 0 && n < 300) begin
        bus.addr_ready = 1'($urandom_range(0, 1));
        bus.flush      = ($urandom_range(0, 11) == 0);
        Reset          = ($urandom_range(0, 99) == 0);
        tick();
        n++;
      end
      bus.flush = 1'b0;
      Reset     = 1'b0;
      if (mq.size() != 0) begin
        total++;
        bad++;
        $display("FAIL random drain timeout remaining=%0d required=0", mq.size());
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
